// File: rtl/piso_serializer_pkg.sv
// Shared constants for the parallel-in / serial-out serializer blocks.
// FSM state and bit-order encodings are fixed values relied on by the datapath.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b1;
    localparam logic DIR_MSB_FIRST = 1'b0;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 64;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle for piso_serializer.
// master drives words and serial back-pressure; slave is the serializer.
interface piso_serializer_if #(
    parameter int unsigned N = 8
) ();

    logic         in_valid;
    logic [N-1:0] in_data;
    logic         shift_dir;
    logic         in_ready;

    logic         ser_ready;
    logic         ser_valid;
    logic         ser_bit;
    logic         ser_first;
    logic         ser_last;
    logic         busy;

    modport master (
        output in_valid, in_data, shift_dir, ser_ready,
        input  in_ready, ser_valid, ser_bit, ser_first, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data, shift_dir, ser_ready,
        output in_ready, ser_valid, ser_bit, ser_first, ser_last, busy
    );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-N bit position counter; clear has priority over enable, wraps after N-1.
import piso_serializer_pkg::*;

module bit_counter #(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    output logic [cnt_width(N)-1:0]   count,
    output logic                      tc
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready on both sides.
// A new word may be loaded on the last-bit transfer, so back-to-back words have no bubble.
import piso_serializer_pkg::*;

module piso_serializer #(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    localparam int unsigned CW = cnt_width(N);

    state_t        state;
    logic [N-1:0]  sreg;
    logic          dir_q;
    logic [CW-1:0] count;
    logic          tc;

    logic          in_shift;
    logic          last_bit;
    logic          xfer;
    logic          accept;
    logic [N-1:0]  sreg_next;

    assign in_shift = (state == SHIFT);
    assign last_bit = in_shift && tc;
    assign xfer     = in_shift && bus.ser_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    assign sreg_next = (dir_q == DIR_LSB_FIRST) ? {1'b0, sreg[N-1:1]}
                                                : {sreg[N-2:0], 1'b0};

    bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (xfer),
        .count  (count),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            dir_q <= DIR_MSB_FIRST;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= bus.in_data;
                        dir_q <= bus.shift_dir;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        // Reload on the last bit when a word is waiting; otherwise drain to IDLE.
                        if (tc && accept) begin
                            sreg  <= bus.in_data;
                            dir_q <= bus.shift_dir;
                        end else begin
                            sreg <= sreg_next;
                            if (tc) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !in_shift || (last_bit && bus.ser_ready);
    assign bus.ser_valid = in_shift;
    assign bus.busy      = in_shift;
    assign bus.ser_bit   = (dir_q == DIR_LSB_FIRST) ? sreg[0] : sreg[N-1];
    assign bus.ser_first = in_shift && (count == '0);
    assign bus.ser_last  = last_bit;

endmodule
